// File: rtl/disp_scan.sv
// rtl/disp_scan.sv - four-digit multiplexed display scanner feeding the 7-segment decoder
// Latches a hex value plus dp/blank masks and scans digits with an anti-ghosting guard.

module disp_scan #(
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        lz_en,
  output logic [3:0]  AN,
  output logic [3:0]  D,
  output logic        DP,
  output logic        tick
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LP_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic          r_adv;
  logic [15:0]   r_data;
  logic [3:0]    r_dp;
  logic [3:0]    r_blank;

  logic          w_wrap;
  logic          w_guard;
  logic [3:0]    w_nib;
  logic [3:0]    w_zero;
  logic          w_lz;
  logic          w_dark;

  assign w_wrap = (r_cnt == LP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_adv   <= 1'b0;
      r_data  <= 16'h0000;
      r_dp    <= 4'h0;
      r_blank <= 4'h0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) begin
        r_idx <= r_idx + 2'd1;
      end
      // r_adv marks the first cycle of a new slot so tick lines up with the new digit's outputs
      r_adv <= w_wrap;
      if (load) begin
        r_data  <= data;
        r_dp    <= dp_in;
        r_blank <= blank_in;
      end
    end
  end

  generate
    if (GUARD == 0) begin : g_no_guard
      assign w_guard = 1'b0;
    end else begin : g_guard
      assign w_guard = (r_cnt < CW'(GUARD));
    end
  endgenerate

  assign w_nib = 4'(r_data >> {r_idx, 2'b00});

  // w_zero[i]: nibbles 3..i of the shadow value are all zero
  assign w_zero[3] = (r_data[15:12] == 4'h0);
  assign w_zero[2] = w_zero[3] && (r_data[11:8] == 4'h0);
  assign w_zero[1] = w_zero[2] && (r_data[7:4] == 4'h0);
  assign w_zero[0] = w_zero[1] && (r_data[3:0] == 4'h0);

  assign w_lz   = lz_en && (r_idx != 2'd0) && w_zero[r_idx];
  assign w_dark = r_blank[r_idx] || w_lz || w_guard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      AN   <= 4'hF;
      D    <= 4'h0;
      DP   <= 1'b1;
      tick <= 1'b0;
    end else begin
      AN   <= w_dark ? 4'hF : ~(4'b0001 << r_idx);
      D    <= w_nib;
      DP   <= w_dark || !r_dp[r_idx];
      tick <= r_adv;
    end
  end

endmodule
